// File: rtl/if_fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
//   imem_req   : fetch stage requests an instruction
//   imem_addr  : request address; held until the request is acknowledged
//   imem_ack   : one-cycle acknowledge; imem_rdata is valid in the same cycle
//   imem_rdata : fetched instruction word
// The master modport is for the fetch stage; the slave modport is for the memory.
interface if_fetch_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register.
// Issues instruction-memory requests and tolerates variable-latency acknowledges.
// A hazard freezes IF/ID. A taken branch from EXE flushes IF/ID and redirects fetch.
// Ports:
//   clk, rst          : clock and synchronous active-low reset (0 = reset)
//   hazard            : freeze request from the hazard detection unit
//   branch_taken/addr : single-cycle redirect from EXE and its target
//   imem              : instruction-memory bus (master side)
//   valid_out         : IF/ID holds a real instruction
//   instr_out, pc_out : IF/ID instruction and the PC+4 of that instruction
module if_fetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hazard,
  input  logic                  branch_taken,
  input  logic [ADDR_W-1:0]     branch_addr,
  if_fetch_stage_if.master      imem,
  output logic                  valid_out,
  output logic [DATA_W-1:0]     instr_out,
  output logic [ADDR_W-1:0]     pc_out
);

  // FETCH   : request outstanding at fetch_addr.
  // FULL    : one instruction is parked in the buffer; no request.
  // DISCARD : a redirect arrived while the request was pending; its ack is dropped.
  localparam logic [1:0] ST_FETCH   = 2'd0;
  localparam logic [1:0] ST_FULL    = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic [DATA_W-1:0] buf_instr_q, buf_instr_d;
  logic [ADDR_W-1:0] buf_pc_q, buf_pc_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] next_addr;

  // PC arithmetic wraps modulo 2^ADDR_W.
  assign next_addr = fetch_addr_q + ADDR_W'(4);

  assign imem.imem_req  = (state_q != ST_FULL);
  assign imem.imem_addr = fetch_addr_q;
  assign valid_out      = valid_q;
  assign instr_out      = instr_q;
  assign pc_out         = pc_q;

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    target_d     = target_q;
    buf_instr_d  = buf_instr_q;
    buf_pc_d     = buf_pc_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    pc_d         = pc_q;

    case (state_q)
      ST_FETCH: begin
        if (imem.imem_ack) begin
          if (branch_taken) begin
            fetch_addr_d = branch_addr;
            valid_d      = 1'b0;
            instr_d      = '0;
          end else if (!hazard) begin
            valid_d      = 1'b1;
            instr_d      = imem.imem_rdata;
            pc_d         = next_addr;
            fetch_addr_d = next_addr;
          end else begin
            // ID is frozen: park the returned instruction instead of losing it.
            buf_instr_d  = imem.imem_rdata;
            buf_pc_d     = next_addr;
            fetch_addr_d = next_addr;
            state_d      = ST_FULL;
          end
        end else if (branch_taken) begin
          // The request cannot be withdrawn, so remember the target and
          // swallow the stale ack when it eventually arrives.
          target_d = branch_addr;
          valid_d  = 1'b0;
          instr_d  = '0;
          state_d  = ST_DISCARD;
        end else if (!hazard) begin
          valid_d = 1'b0;
        end
      end

      ST_FULL: begin
        if (branch_taken) begin
          valid_d      = 1'b0;
          instr_d      = '0;
          fetch_addr_d = branch_addr;
          state_d      = ST_FETCH;
        end else if (!hazard) begin
          valid_d = 1'b1;
          instr_d = buf_instr_q;
          pc_d    = buf_pc_q;
          state_d = ST_FETCH;
        end
      end

      ST_DISCARD: begin
        valid_d = 1'b0;
        instr_d = '0;
        if (imem.imem_ack) begin
          fetch_addr_d = branch_taken ? branch_addr : target_q;
          state_d      = ST_FETCH;
        end else if (branch_taken) begin
          target_d = branch_addr;
        end
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_FETCH;
      fetch_addr_q <= RESET_PC;
      target_q     <= '0;
      buf_instr_q  <= '0;
      buf_pc_q     <= '0;
      valid_q      <= 1'b0;
      instr_q      <= '0;
      pc_q         <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      target_q     <= target_d;
      buf_instr_q  <= buf_instr_d;
      buf_pc_q     <= buf_pc_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          hazard = 1'b0;
  logic          branch_taken = 1'b0;
  logic [AW-1:0] branch_addr = '0;
  logic          valid_out;
  logic [DW-1:0] instr_out;
  logic [AW-1:0] pc_out;

  if_fetch_stage_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  if_fetch_stage #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC('0)) dut (
    .clk          (clk),
    .rst          (rst),
    .hazard       (hazard),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem         (bus.master),
    .valid_out    (valid_out),
    .instr_out    (instr_out),
    .pc_out       (pc_out)
  );

  always #5 clk = ~clk;

  // Reference model: an outstanding-request address, a "request is stale" flag,
  // a pending redirect target, a queue holding at most one fetched-but-undelivered
  // instruction, and the instruction currently presented to ID.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } item_t;

  logic [31:0] m_addr;
  logic        m_stale;
  logic [31:0] m_target;
  item_t       m_buf[$];
  logic        m_v;
  logic [31:0] m_i;
  logic [31:0] m_p;

  int vectors    = 0;
  int miscompares = 0;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic h, input logic b,
                       input logic [31:0] ba, input logic ack);
    item_t it;
    if (!r) begin
      m_addr = 32'h0; m_stale = 1'b0; m_target = 32'h0;
      m_buf.delete();
      m_v = 1'b0; m_i = 32'h0; m_p = 32'h0;
    end else if (m_buf.size() != 0) begin
      if (b) begin
        m_buf.delete();
        m_v = 1'b0; m_i = 32'h0;
        m_addr = ba;
      end else if (!h) begin
        it = m_buf.pop_front();
        m_v = 1'b1; m_i = it.instr; m_p = it.pc4;
      end
    end else if (m_stale) begin
      if (ack) begin
        m_addr = b ? ba : m_target;
        m_stale = 1'b0;
      end else if (b) begin
        m_target = ba;
      end
    end else if (b) begin
      m_v = 1'b0; m_i = 32'h0;
      if (ack) m_addr = ba;
      else begin
        m_stale = 1'b1;
        m_target = ba;
      end
    end else if (ack) begin
      it.instr = pat(m_addr);
      it.pc4   = m_addr + 32'd4;
      m_addr   = m_addr + 32'd4;
      if (h) m_buf.push_back(it);
      else begin
        m_v = 1'b1; m_i = it.instr; m_p = it.pc4;
      end
    end else if (!h) begin
      m_v = 1'b0;
    end
  endtask

  // One clock: drive inputs at the falling edge, let the memory ack only
  // while a request is outstanding, advance the model, check after the edge.
  task automatic step(input logic r, input logic h, input logic b,
                      input logic [31:0] ba, input logic ackw);
    logic ack;
    @(negedge clk);
    ack = ackw & (m_buf.size() == 0);
    rst = r; hazard = h; branch_taken = b; branch_addr = ba;
    bus.imem_ack   = ack;
    bus.imem_rdata = pat(bus.imem_addr);
    model(r, h, b, ba, ack);
    @(posedge clk);
    #1;
    chk("imem_req",  {31'd0, bus.imem_req}, {31'd0, (m_buf.size() == 0)});
    chk("imem_addr", bus.imem_addr, m_addr);
    chk("valid_out", {31'd0, valid_out}, {31'd0, m_v});
    chk("instr_out", instr_out, m_i);
    chk("pc_out",    pc_out, m_p);
  endtask

  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;

    // Reset, then a zero-wait-state stream.
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("reset_addr", bus.imem_addr, 32'h0);
    chk("reset_valid", {31'd0, valid_out}, 32'd0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1);
    chk("stream_pc", pc_out, 32'd16);

    // Hazard for three cycles while memory keeps acking.
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 1);
    chk("full_req", {31'd0, bus.imem_req}, 32'd0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1);

    // Two wait states per access.
    for (int i = 0; i < 9; i++) step(1, 0, 0, 0, (i % 3) == 2);

    // Redirect to 0x20, then a branch to 0x100 while the 0x20 request waits.
    step(1, 0, 1, 32'h20, 1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 32'h100, 0);
    step(1, 0, 0, 0, 0);
    chk("discard_addr", bus.imem_addr, 32'h20);
    step(1, 0, 0, 0, 1);
    chk("redirect_addr", bus.imem_addr, 32'h100);
    chk("gap_valid", {31'd0, valid_out}, 32'd0);
    step(1, 0, 0, 0, 1);

    // Fill the buffer, then branch to 0x40 with hazard still asserted.
    step(1, 1, 0, 0, 1);
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 32'h40, 0);
    chk("full_branch_addr", bus.imem_addr, 32'h40);
    chk("full_branch_valid", {31'd0, valid_out}, 32'd0);
    step(1, 0, 0, 0, 1);

    // PC wrap at the top of the address space.
    step(1, 0, 1, 32'hFFFF_FFFC, 1);
    step(1, 0, 0, 0, 1);
    chk("wrap_pc", pc_out, 32'h0);
    step(1, 0, 0, 0, 1);

    // Reset while discarding, with the stale ack in the same cycle.
    step(1, 0, 1, 32'h80, 0);
    step(0, 0, 0, 0, 1);
    chk("rst_discard_addr", bus.imem_addr, 32'h0);
    chk("rst_discard_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_discard_instr", instr_out, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      logic r, h, b, a;
      logic [31:0] ba;
      r  = ($urandom_range(0, 99) >= 2);
      h  = ($urandom_range(0, 99) < 30);
      b  = ($urandom_range(0, 99) < 10);
      a  = ($urandom_range(0, 99) < 55);
      ba = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      if ($urandom_range(0, 9) == 0) ba = 32'hFFFF_FFF8;
      step(r, h, b, ba, a);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register. Sits directly upstream of the decode stage and the hazard detection unit.
- Issues requests to instruction memory and tolerates variable-latency acknowledgements.
- Freezes on a hazard stall and flushes or redirects on a taken branch from EXE.
- Outputs feed ID: the instruction and PC+4.

Parameters:
ADDR_W, 32, address and PC width
DATA_W, 32, instruction width
RESET_PC, 0, first fetch address after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-low reset (0 = reset)
hazard  in  1  freeze request from hazard detection unit
branch_taken  in  1  redirect from EXE, single cycle
branch_addr  in  ADDR_W  redirect target
imem_req  out  1  instruction memory request
imem_addr  out  ADDR_W  request address, stable while imem_req=1 and no ack
imem_ack  in  1  one-cycle ack; imem_rdata valid in the same cycle
imem_rdata  in  DATA_W  fetched instruction
valid_out  out  1  IF/ID holds a real instruction
instr_out  out  DATA_W  IF/ID instruction
pc_out  out  ADDR_W  IF/ID PC+4 of that instruction

Behaviour:
- Reset (rst=0 at clk edge):
  - state=FETCH, fetch_addr=RESET_PC.
  - valid_out=0, instr_out=0, pc_out=0.
  - buffer cleared.
  - Applies from any state; an outstanding request is abandoned, and any ack arriving in that cycle is ignored.
- imem_req is 1 in FETCH and DISCARD, 0 in FULL. imem_addr = fetch_addr register.
- Memory handshake:
  - Memory may ack in the same cycle the request is raised, giving 0 wait states and 1 instr/cycle.
  - The address changes only on the edge that samples ack or on a redirect out of FULL.
- FETCH:
  - ack & branch_taken: data dropped; fetch_addr<=branch_addr; IF/ID flushed (valid_out=0, instr_out=0); stay FETCH.
  - ack & ~branch & ~hazard: IF/ID<=(1, imem_rdata, fetch_addr+4); fetch_addr+=4; stay FETCH.
  - ack & ~branch & hazard: IF/ID held; buffer<=(imem_rdata, fetch_addr+4); fetch_addr+=4; go FULL.
  - ~ack & branch: target<=branch_addr; IF/ID flushed; go DISCARD. The request stays at the old address.
  - ~ack & ~branch: if hazard, IF/ID held; else valid_out<=0 (bubble; instr_out/pc_out hold).
- FULL:
  - branch: buffer dropped; IF/ID flushed; fetch_addr<=branch_addr; go FETCH.
  - ~hazard: IF/ID<=(1, buffer); go FETCH.
  - hazard: hold everything.
- DISCARD:
  - Waits for the stale ack; its data is never written to IF/ID.
  - ack: fetch_addr<=target (or branch_addr if branch_taken that cycle); go FETCH.
  - ~ack & branch: target<=branch_addr.
  - IF/ID remains flushed.
- Priority: rst > branch_taken > hazard.
- A flush overrides a hold: branch_taken with hazard=1 still clears IF/ID.
- PC arithmetic: modulo 2^ADDR_W. 0xFFFFFFFC+4 wraps to 0 with no flag.
- hazard only freezes IF/ID and the buffer. It never cancels or reissues an outstanding memory request.
- At most one instruction is buffered. No instruction is lost or duplicated under any hazard/ack pattern.

Test Plan:
- Reset, rst=1, ack tied 1, rdata=addr-derived pattern: imem_addr sequence 0,4,8,…; valid_out=1 from cycle 2; pc_out=4,8,12 on successive cycles.
- 0-wait stream, hazard=1 for 3 cycles while ack=1: the instruction from addr 8 is buffered, req drops, and IF/ID holds the instruction from 4. On hazard release, the 8 instruction appears (pc_out=12), then fetch resumes at 12 with no gap or duplicate.
- 2-wait-state memory (ack every 3rd cycle), hazard=0: valid_out pattern 0,0,1 repeating; pc_out steps by 4 per valid.
- Branch to 0x100 one cycle after a request to 0x20 issued, ack 2 cycles later: imem_addr stays 0x20 until ack; the 0x20 data is never valid_out; next request at 0x100; valid_out=0 throughout the gap.
- FULL state with hazard=1, then branch_taken=1 to 0x40: buffer discarded, IF/ID flushed the same edge, next imem_addr=0x40.
- rst=0 asserted in DISCARD with ack arriving the same cycle: next state FETCH, imem_addr=RESET_PC, all outputs 0.
